// File: rtl/multicycle_control_fsm.sv
// Multicycle processor control unit: a Moore FSM. Only FETCH and BRANCH
// let pcen/irwrite follow the memready/zero inputs combinationally.
module multicycle_control_fsm (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_op,
    input  logic       i_zero,
    input  logic       i_memready,
    output logic [1:0] o_aluop,
    output logic       o_irwrite,
    output logic       o_pcen,
    output logic       o_regwrite,
    output logic       o_memwrite,
    output logic       o_iord,
    output logic       o_memtoreg,
    output logic       o_regdst,
    output logic       o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_pcsrc,
    output logic [3:0] o_state
);

    localparam logic [3:0] OpRtype = 4'b0000;
    localparam logic [3:0] OpLw    = 4'b0001;
    localparam logic [3:0] OpSw    = 4'b0010;
    localparam logic [3:0] OpAddi  = 4'b0011;
    localparam logic [3:0] OpCbz   = 4'b0100;
    localparam logic [3:0] OpB     = 4'b0101;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StAddiEx  = 4'd8,
        StAddiWb  = 4'd9,
        StBranch  = 4'd10,
        StJump    = 4'd11
    } state_e;

    state_e r_state;
    state_e w_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = StFetch;
        o_aluop    = 2'b00;
        o_irwrite  = 1'b0;
        o_pcen     = 1'b0;
        o_regwrite = 1'b0;
        o_memwrite = 1'b0;
        o_iord     = 1'b0;
        o_memtoreg = 1'b0;
        o_regdst   = 1'b0;
        o_alusrca  = 1'b0;
        o_alusrcb  = 2'b00;
        o_pcsrc    = 2'b00;
        case (r_state)
            StFetch: begin
                o_alusrcb = 2'b01;
                o_irwrite = i_memready;
                o_pcen    = i_memready;
                w_next    = i_memready ? StDecode : StFetch;
            end
            StDecode: begin
                o_alusrcb = 2'b11;
                case (i_op)
                    OpLw, OpSw: w_next = StMemAdr;
                    OpRtype:    w_next = StRtypeEx;
                    OpAddi:     w_next = StAddiEx;
                    OpCbz:      w_next = StBranch;
                    OpB:        w_next = StJump;
                    default:    w_next = StFetch;
                endcase
            end
            StMemAdr: begin
                o_alusrca = 1'b1;
                o_alusrcb = 2'b10;
                w_next    = (i_op == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                o_iord = 1'b1;
                w_next = i_memready ? StMemWb : StMemRd;
            end
            StMemWb: begin
                o_memtoreg = 1'b1;
                o_regwrite = 1'b1;
            end
            StMemWr: begin
                o_iord     = 1'b1;
                o_memwrite = 1'b1;
                w_next     = i_memready ? StFetch : StMemWr;
            end
            StRtypeEx: begin
                o_alusrca = 1'b1;
                o_aluop   = 2'b10;
                w_next    = StRtypeWb;
            end
            StRtypeWb: begin
                o_regdst   = 1'b1;
                o_regwrite = 1'b1;
            end
            StAddiEx: begin
                o_alusrca = 1'b1;
                o_alusrcb = 2'b10;
                w_next    = StAddiWb;
            end
            StAddiWb: begin
                o_regwrite = 1'b1;
            end
            StBranch: begin
                o_alusrca = 1'b1;
                o_aluop   = 2'b01;
                o_pcsrc   = 2'b01;
                o_pcen    = i_zero;
            end
            StJump: begin
                o_pcsrc = 2'b10;
                o_pcen  = 1'b1;
            end
            // Illegal codes 12-15 keep all defaults and return to FETCH.
            default: w_next = StFetch;
        endcase
    end

    assign o_state = r_state;

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 Parameters: none; opcode encodings fixed: RTYPE 4'b0000, LW 4'b0001, SW 4'b0010, ADDI 4'b0011, CBZ 4'b0100, B 4'b0101.
REQ-002 clk  input  1  single clock, all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  4  opcode field of the instruction register.
REQ-005 zero  input  1  ALU zero flag, sampled combinationally in BRANCH.
REQ-006 memready  input  1  memory handshake; current access completes in the cycle it is high.
REQ-007 aluop  output  2  ALU operation class for the ALU decoder: 00 add, 01 sub, 10 use funct.
REQ-008 irwrite, pcen, regwrite, memwrite, iord, memtoreg, regdst, alusrca  output  1 each  datapath strobes and selects.
REQ-009 alusrcb, pcsrc  output  2 each  ALU B-operand select and next-PC select.
REQ-010 state  output  4  current state encoding, for debug.

Function
REQ-011 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, ADDIEX 8, ADDIWB 9, BRANCH 10, JUMP 11; codes 12-15 are illegal.
REQ-012 FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcen=memready; stay while memready=0, go to DECODE when memready=1.
REQ-013 DECODE: alusrca=0, alusrcb=11, aluop=00; next: LW/SW->MEMADR, RTYPE->RTYPEEX, ADDI->ADDIEX, CBZ->BRANCH, B->JUMP, any other op->FETCH.
REQ-014 MEMADR: alusrca=1, alusrcb=10, aluop=00; next MEMRD if op=LW, else MEMWR.
REQ-015 MEMRD: iord=1; hold until memready=1, then MEMWB.
REQ-016 MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-017 MEMWR: iord=1, memwrite=1 for every cycle in state; hold until memready=1, then FETCH.
REQ-018 RTYPEEX: alusrca=1, alusrcb=00, aluop=10; next RTYPEWB.
REQ-019 RTYPEWB: regdst=1, memtoreg=0, regwrite=1; next FETCH.
REQ-020 ADDIEX: alusrca=1, alusrcb=10, aluop=00; next ADDIWB.
REQ-021 ADDIWB: regdst=0, memtoreg=0, regwrite=1; next FETCH.
REQ-022 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero; next FETCH unconditionally.
REQ-023 JUMP: pcsrc=10, pcen=1; next FETCH.
REQ-024 Every output not listed for a state is 0 (aluop=00, alusrcb=00, pcsrc=00).
REQ-025 Outputs are combinational from state; only irwrite/pcen (FETCH) and pcen (BRANCH) additionally depend on inputs.
REQ-026 Illegal state codes: all outputs 0, next state FETCH.
REQ-027 Cycle counts with memready=1 throughout: LW 5, SW 4, RTYPE 4, ADDI 4, CBZ 3, B 3.
REQ-028 op is sampled only in DECODE and MEMADR; changes in other states have no effect.

Reset
REQ-029 reset=1 at a rising edge forces state=FETCH regardless of current state, including mid-wait in MEMRD/MEMWR.
REQ-030 While state=FETCH after reset, outputs are exactly the FETCH values of REQ-012.
REQ-031 reset takes priority over memready and every transition in the same cycle.

Verification
REQ-032 Reset, memready=1, op=LW -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-033 op=SW, memready low 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then state 0.
REQ-034 op=RTYPE -> aluop=10 only in state 6; regdst=1, regwrite=1 in state 7.
REQ-035 op=CBZ with zero=1 -> pcen=1, pcsrc=01 in state 10; repeat with zero=0 -> pcen=0, then state 0.
REQ-036 op=4'b1111 -> states 0,1,0 with regwrite, memwrite, pcen all 0 in state 1.
REQ-037 reset asserted while in MEMRD with memready=0 -> next state 0, iord=0, irwrite follows memready.
